// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - write-back queue feeding the register-file write port
// Two-source in-order FIFO, one drain per cycle, with youngest-first forwarding.
module wb_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    LD_VALID,
    output logic                    LD_READY,
    input  logic [4:0]              LD_ADDR,
    input  logic [DATA_WIDTH-1:0]   LD_DATA,
    input  logic                    ALU_VALID,
    output logic                    ALU_READY,
    input  logic [4:0]              ALU_ADDR,
    input  logic [DATA_WIDTH-1:0]   ALU_DATA,
    output logic                    WE,
    output logic [4:0]              A3,
    output logic [DATA_WIDTH-1:0]   WD3,
    input  logic [4:0]              A1,
    input  logic [4:0]              A2,
    output logic                    FWD1_HIT,
    output logic                    FWD2_HIT,
    output logic [DATA_WIDTH-1:0]   FWD1_DATA,
    output logic [DATA_WIDTH-1:0]   FWD2_DATA,
    output logic [$clog2(DEPTH):0]  COUNT,
    output logic                    EMPTY
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [4:0]            r_mem_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    logic                  r_we;
    logic [4:0]            r_a3;
    logic [DATA_WIDTH-1:0] r_wd3;

    logic                  w_ld_ready;
    logic                  w_alu_ready;
    logic                  w_ld_push;
    logic                  w_alu_push;
    logic                  w_pop;
    logic [PW-1:0]         w_alu_slot;
    logic                  w_fwd1_hit;
    logic                  w_fwd2_hit;
    logic [DATA_WIDTH-1:0] w_fwd1_data;
    logic [DATA_WIDTH-1:0] w_fwd2_data;

    // Ready comes only from registered occupancy; the same-cycle pop is not credited.
    assign w_ld_ready  = (r_count < CW'(DEPTH));
    assign w_alu_ready = LD_VALID ? (r_count <= CW'(DEPTH - 2)) : (r_count < CW'(DEPTH));

    assign w_ld_push  = LD_VALID  & w_ld_ready  & (LD_ADDR  != 5'd0);
    assign w_alu_push = ALU_VALID & w_alu_ready & (ALU_ADDR != 5'd0);
    assign w_pop      = (r_count != '0);
    assign w_alu_slot = r_tail + PW'(w_ld_push);

    always_ff @(posedge CLK) begin
        if (w_ld_push) begin
            r_mem_addr[r_tail] <= LD_ADDR;
            r_mem_data[r_tail] <= LD_DATA;
        end
        if (w_alu_push) begin
            r_mem_addr[w_alu_slot] <= ALU_ADDR;
            r_mem_data[w_alu_slot] <= ALU_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_we    <= 1'b0;
            r_a3    <= 5'd0;
            r_wd3   <= '0;
        end else begin
            r_tail  <= r_tail + PW'(w_ld_push) + PW'(w_alu_push);
            r_count <= r_count + CW'(w_ld_push) + CW'(w_alu_push) - CW'(w_pop);
            if (w_pop) begin
                r_we   <= 1'b1;
                r_a3   <= r_mem_addr[r_head];
                r_wd3  <= r_mem_data[r_head];
                r_head <= r_head + PW'(1);
            end else begin
                r_we   <= 1'b0;
            end
        end
    end

    // Oldest first so that later (younger) matches overwrite earlier ones.
    always_comb begin
        w_fwd1_hit  = 1'b0;
        w_fwd2_hit  = 1'b0;
        w_fwd1_data = '0;
        w_fwd2_data = '0;
        if (r_we && (A1 != 5'd0) && (r_a3 == A1)) begin
            w_fwd1_hit  = 1'b1;
            w_fwd1_data = r_wd3;
        end
        if (r_we && (A2 != 5'd0) && (r_a3 == A2)) begin
            w_fwd2_hit  = 1'b1;
            w_fwd2_data = r_wd3;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && (A1 != 5'd0) && (r_mem_addr[r_head + PW'(i)] == A1)) begin
                w_fwd1_hit  = 1'b1;
                w_fwd1_data = r_mem_data[r_head + PW'(i)];
            end
            if ((CW'(i) < r_count) && (A2 != 5'd0) && (r_mem_addr[r_head + PW'(i)] == A2)) begin
                w_fwd2_hit  = 1'b1;
                w_fwd2_data = r_mem_data[r_head + PW'(i)];
            end
        end
    end

    assign LD_READY  = w_ld_ready;
    assign ALU_READY = w_alu_ready;
    assign WE        = r_we;
    assign A3        = r_a3;
    assign WD3       = r_wd3;
    assign FWD1_HIT  = w_fwd1_hit;
    assign FWD2_HIT  = w_fwd2_hit;
    assign FWD1_DATA = w_fwd1_data;
    assign FWD2_DATA = w_fwd2_data;
    assign COUNT     = r_count;
    assign EMPTY     = (r_count == '0) && !r_we;

endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - directed self-checking bench for wb_queue
module tb_wb_queue;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        LD_VALID = 1'b0;
    logic        LD_READY;
    logic [4:0]  LD_ADDR = 5'd0;
    logic [31:0] LD_DATA = 32'd0;
    logic        ALU_VALID = 1'b0;
    logic        ALU_READY;
    logic [4:0]  ALU_ADDR = 5'd0;
    logic [31:0] ALU_DATA = 32'd0;
    logic        WE;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [4:0]  A1 = 5'd0;
    logic [4:0]  A2 = 5'd0;
    logic        FWD1_HIT, FWD2_HIT;
    logic [31:0] FWD1_DATA, FWD2_DATA;
    logic [2:0]  COUNT;
    logic        EMPTY;

    int vectors = 0;
    int miscompares = 0;

    wb_queue #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
        .ALU_VALID(ALU_VALID), .ALU_READY(ALU_READY), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA),
        .WE(WE), .A3(A3), .WD3(WD3), .A1(A1), .A2(A2),
        .FWD1_HIT(FWD1_HIT), .FWD2_HIT(FWD2_HIT), .FWD1_DATA(FWD1_DATA), .FWD2_DATA(FWD2_DATA),
        .COUNT(COUNT), .EMPTY(EMPTY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #2 RST = 1'b0;
        #2;
        vectors++; if (WE !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b expected 0", WE); end
        vectors++; if (A3 !== 5'd0) begin miscompares++; $display("FAIL reset_a3: got %0d expected 0", A3); end
        vectors++; if (WD3 !== 32'd0) begin miscompares++; $display("FAIL reset_wd3: got %h expected 0", WD3); end
        vectors++; if (COUNT !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", COUNT); end
        vectors++; if (EMPTY !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b expected 1", EMPTY); end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        vectors++; if (LD_READY !== 1'b1 || ALU_READY !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got ld=%b alu=%b expected 1/1", LD_READY, ALU_READY); end
        step();
    endtask

    task automatic test_single_write();
        ALU_VALID = 1'b1; ALU_ADDR = 5'd5; ALU_DATA = 32'h12345678;
        #1;
        vectors++; if (ALU_READY !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b expected 1", ALU_READY); end
        step();
        ALU_VALID = 1'b0; A1 = 5'd5;
        #1;
        vectors++; if (COUNT !== 3'd1 || WE !== 1'b0 || EMPTY !== 1'b0) begin miscompares++; $display("FAIL single_queued: got count=%0d we=%b empty=%b expected 1/0/0", COUNT, WE, EMPTY); end
        vectors++; if (FWD1_HIT !== 1'b1 || FWD1_DATA !== 32'h12345678) begin miscompares++; $display("FAIL single_fwd_fifo: got hit=%b data=%h expected 1/12345678", FWD1_HIT, FWD1_DATA); end
        step();
        vectors++; if (WE !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'h12345678) begin miscompares++; $display("FAIL single_out: got we=%b a3=%0d wd3=%h expected 1/5/12345678", WE, A3, WD3); end
        vectors++; if (FWD1_HIT !== 1'b1 || FWD1_DATA !== 32'h12345678 || COUNT !== 3'd0) begin miscompares++; $display("FAIL single_fwd_out: got hit=%b data=%h count=%0d expected 1/12345678/0", FWD1_HIT, FWD1_DATA, COUNT); end
        step();
        vectors++; if (WE !== 1'b0 || EMPTY !== 1'b1 || A3 !== 5'd5) begin miscompares++; $display("FAIL single_done: got we=%b empty=%b a3=%0d expected 0/1/5", WE, EMPTY, A3); end
        vectors++; if (FWD1_HIT !== 1'b0 || FWD1_DATA !== 32'd0) begin miscompares++; $display("FAIL single_fwd_gone: got hit=%b data=%h expected 0/0", FWD1_HIT, FWD1_DATA); end
        A1 = 5'd0;
    endtask

    task automatic test_dual_accept();
        LD_VALID = 1'b1; LD_ADDR = 5'd3; LD_DATA = 32'hAAAA0000;
        ALU_VALID = 1'b1; ALU_ADDR = 5'd4; ALU_DATA = 32'hBBBB0000;
        #1;
        vectors++; if (LD_READY !== 1'b1 || ALU_READY !== 1'b1) begin miscompares++; $display("FAIL dual_ready: got ld=%b alu=%b expected 1/1", LD_READY, ALU_READY); end
        step();
        LD_VALID = 1'b0; ALU_VALID = 1'b0;
        vectors++; if (COUNT !== 3'd2 || WE !== 1'b0) begin miscompares++; $display("FAIL dual_count: got count=%0d we=%b expected 2/0", COUNT, WE); end
        step();
        vectors++; if (WE !== 1'b1 || A3 !== 5'd3 || WD3 !== 32'hAAAA0000) begin miscompares++; $display("FAIL dual_first: got we=%b a3=%0d wd3=%h expected 1/3/aaaa0000", WE, A3, WD3); end
        step();
        vectors++; if (WE !== 1'b1 || A3 !== 5'd4 || WD3 !== 32'hBBBB0000) begin miscompares++; $display("FAIL dual_second: got we=%b a3=%0d wd3=%h expected 1/4/bbbb0000", WE, A3, WD3); end
        step();
        vectors++; if (WE !== 1'b0 || EMPTY !== 1'b1) begin miscompares++; $display("FAIL dual_drained: got we=%b empty=%b expected 0/1", WE, EMPTY); end
    endtask

    task automatic test_full_backpressure();
        logic [36:0] q[$];
        logic [36:0] exp_out;
        int li = 0, ai = 0, mc = 0, seen = 0;
        bit ld_v, alu_v, exp_ld, exp_alu, do_pop, saw_block;
        bit done = 0;
        saw_block = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            ld_v = (li < 5); alu_v = (ai < 5);
            LD_VALID = ld_v;  LD_ADDR = 5'(10 + li);  LD_DATA = 32'h10000000 + 32'(li);
            ALU_VALID = alu_v; ALU_ADDR = 5'(20 + ai); ALU_DATA = 32'h20000000 + 32'(ai);
            #1;
            exp_ld  = (mc < 4);
            exp_alu = ld_v ? (mc <= 2) : (mc < 4);
            vectors++; if (LD_READY !== exp_ld || ALU_READY !== exp_alu) begin miscompares++; $display("FAIL bp_ready cyc%0d: got ld=%b alu=%b expected %b/%b", cyc, LD_READY, ALU_READY, exp_ld, exp_alu); end
            if (mc == 3 && ld_v && ALU_READY === 1'b0) saw_block = 1;
            do_pop = (mc > 0);
            exp_out = '0;
            if (do_pop) exp_out = q.pop_front();
            if (ld_v && exp_ld) begin q.push_back({LD_ADDR, LD_DATA}); li++; end
            if (alu_v && exp_alu) begin q.push_back({ALU_ADDR, ALU_DATA}); ai++; end
            mc = q.size();
            step();
            vectors++; if (COUNT !== 3'(mc) || WE !== do_pop) begin miscompares++; $display("FAIL bp_state cyc%0d: got count=%0d we=%b expected %0d/%b", cyc, COUNT, WE, mc, do_pop); end
            if (do_pop) begin
                seen++;
                vectors++; if ({A3, WD3} !== exp_out) begin miscompares++; $display("FAIL bp_order cyc%0d: got %0d/%h expected %0d/%h", cyc, A3, WD3, exp_out[36:32], exp_out[31:0]); end
            end
            if (li == 5 && ai == 5 && mc == 0 && !do_pop) done = 1;
        end
        LD_VALID = 1'b0; ALU_VALID = 1'b0;
        vectors++; if (seen != 10 || !done) begin miscompares++; $display("FAIL bp_total: got %0d writes done=%b expected 10/1", seen, done); end
        vectors++; if (!saw_block) begin miscompares++; $display("FAIL bp_alu_block: got no ALU_READY drop at count 3 expected one"); end
    endtask

    task automatic test_zero_discard();
        ALU_VALID = 1'b1; ALU_ADDR = 5'd0; ALU_DATA = 32'hDEADBEEF;
        A1 = 5'd0;
        #1;
        vectors++; if (ALU_READY !== 1'b1) begin miscompares++; $display("FAIL zero_ready: got %b expected 1", ALU_READY); end
        step();
        ALU_VALID = 1'b0;
        vectors++; if (COUNT !== 3'd0 || FWD1_HIT !== 1'b0 || FWD1_DATA !== 32'd0) begin miscompares++; $display("FAIL zero_discard: got count=%0d hit=%b data=%h expected 0/0/0", COUNT, FWD1_HIT, FWD1_DATA); end
        step();
        vectors++; if (WE !== 1'b0 || EMPTY !== 1'b1) begin miscompares++; $display("FAIL zero_no_write: got we=%b empty=%b expected 0/1", WE, EMPTY); end
        LD_VALID = 1'b1; LD_ADDR = 5'd0; LD_DATA = 32'hCAFE0000;
        ALU_VALID = 1'b1; ALU_ADDR = 5'd9; ALU_DATA = 32'h00000909;
        step();
        LD_VALID = 1'b0; ALU_VALID = 1'b0;
        vectors++; if (COUNT !== 3'd1) begin miscompares++; $display("FAIL zero_mixed_count: got %0d expected 1", COUNT); end
        step();
        vectors++; if (WE !== 1'b1 || A3 !== 5'd9 || WD3 !== 32'h00000909) begin miscompares++; $display("FAIL zero_mixed_out: got we=%b a3=%0d wd3=%h expected 1/9/00000909", WE, A3, WD3); end
        step();
    endtask

    task automatic test_fwd_priority();
        LD_VALID = 1'b1; LD_ADDR = 5'd7; LD_DATA = 32'h1;
        ALU_VALID = 1'b1; ALU_ADDR = 5'd7; ALU_DATA = 32'h2;
        A1 = 5'd7; A2 = 5'd8;
        #1;
        vectors++; if (FWD1_HIT !== 1'b0) begin miscompares++; $display("FAIL fwd_same_cycle: got hit=%b expected 0", FWD1_HIT); end
        step();
        LD_VALID = 1'b0; ALU_VALID = 1'b0;
        vectors++; if (FWD1_HIT !== 1'b1 || FWD1_DATA !== 32'h2) begin miscompares++; $display("FAIL fwd_both_fifo: got hit=%b data=%h expected 1/2", FWD1_HIT, FWD1_DATA); end
        vectors++; if (FWD2_HIT !== 1'b0 || FWD2_DATA !== 32'd0) begin miscompares++; $display("FAIL fwd_miss: got hit=%b data=%h expected 0/0", FWD2_HIT, FWD2_DATA); end
        step();
        vectors++; if (WD3 !== 32'h1 || FWD1_HIT !== 1'b1 || FWD1_DATA !== 32'h2) begin miscompares++; $display("FAIL fwd_fifo_over_out: got wd3=%h hit=%b data=%h expected 1/1/2", WD3, FWD1_HIT, FWD1_DATA); end
        step();
        vectors++; if (COUNT !== 3'd0 || FWD1_HIT !== 1'b1 || FWD1_DATA !== 32'h2) begin miscompares++; $display("FAIL fwd_out_stage: got count=%0d hit=%b data=%h expected 0/1/2", COUNT, FWD1_HIT, FWD1_DATA); end
        step();
        vectors++; if (FWD1_HIT !== 1'b0 || FWD1_DATA !== 32'd0) begin miscompares++; $display("FAIL fwd_drained: got hit=%b data=%h expected 0/0", FWD1_HIT, FWD1_DATA); end
        A1 = 5'd0; A2 = 5'd0;
    endtask

    task automatic test_reset_mid();
        LD_VALID = 1'b1; LD_ADDR = 5'd1; LD_DATA = 32'h11;
        ALU_VALID = 1'b1; ALU_ADDR = 5'd2; ALU_DATA = 32'h22;
        step();
        LD_ADDR = 5'd3; LD_DATA = 32'h33;
        ALU_ADDR = 5'd6; ALU_DATA = 32'h66;
        step();
        LD_VALID = 1'b0; ALU_VALID = 1'b0;
        #1;
        vectors++; if (COUNT !== 3'd3 || WE !== 1'b1 || A3 !== 5'd1) begin miscompares++; $display("FAIL rmid_pre: got count=%0d we=%b a3=%0d expected 3/1/1", COUNT, WE, A3); end
        RST = 1'b0;
        #1;
        vectors++; if (WE !== 1'b0 || A3 !== 5'd0 || WD3 !== 32'd0) begin miscompares++; $display("FAIL rmid_out: got we=%b a3=%0d wd3=%h expected 0/0/0", WE, A3, WD3); end
        vectors++; if (COUNT !== 3'd0 || EMPTY !== 1'b1) begin miscompares++; $display("FAIL rmid_count: got count=%0d empty=%b expected 0/1", COUNT, EMPTY); end
        #10;
        RST = 1'b1;
        #1;
        vectors++; if (LD_READY !== 1'b1 || ALU_READY !== 1'b1) begin miscompares++; $display("FAIL rmid_ready: got ld=%b alu=%b expected 1/1", LD_READY, ALU_READY); end
        step();
        vectors++; if (WE !== 1'b0 || COUNT !== 3'd0) begin miscompares++; $display("FAIL rmid_lost: got we=%b count=%0d expected 0/0", WE, COUNT); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_dual_accept();
        test_full_backpressure();
        test_zero_discard();
        test_fwd_priority();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
# wb_queue

Write-back queue on the register file's write port. It accepts write-back requests from the ALU and the load unit through valid/ready handshakes. Requests are buffered in a small in-order FIFO and drained one per cycle onto the register file's WE/A3/WD3 inputs. It also exposes forwarding lookups, so readers on A1/A2 can see results that are queued but not yet written.

## Interface

- DATA_WIDTH, 32, width of write data
- DEPTH, 4, FIFO entries; power of two, ≥2

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- LD_VALID  in  1  load-unit write-back request
- LD_READY  out  1  load request accepted this cycle when high with LD_VALID
- LD_ADDR  in  5  destination register
- LD_DATA  in  DATA_WIDTH  load result
- ALU_VALID  in  1  ALU write-back request
- ALU_READY  out  1  ALU request accepted when high with ALU_VALID
- ALU_ADDR  in  5  destination register
- ALU_DATA  in  DATA_WIDTH  ALU result
- WE  out  1  register-file write enable (registered)
- A3  out  5  register-file write address (registered)
- WD3  out  DATA_WIDTH  register-file write data (registered)
- A1, A2  in  5 each  read addresses to look up
- FWD1_HIT, FWD2_HIT  out  1 each  pending write exists for A1/A2
- FWD1_DATA, FWD2_DATA  out  DATA_WIDTH each  youngest pending data for A1/A2; 0 when no hit
- COUNT  out  $clog2(DEPTH)+1  FIFO occupancy (excludes the output stage)
- EMPTY  out  1  COUNT==0 and WE==0

## Operation

- **Storage:** FIFO of DEPTH entries {addr, data}, plus head/tail pointers that wrap modulo DEPTH. COUNT is a registered counter.
- **Handshake rules (combinational, from registered COUNT):**
  - LD_READY = COUNT<DEPTH.
  - ALU_READY = COUNT<DEPTH when LD_VALID=0, otherwise COUNT≤DEPTH-2.
  - The pop in the current cycle does not count toward free space.
- **Ordering:** when both requests are accepted in the same cycle, the load is enqueued first (older) and the ALU request second.
- **Register $0:** a request with ADDR==0 completes its handshake but is discarded (not enqueued). It does not consume space in the ready calculation beyond the rules above.
- **Drain:** every cycle that COUNT>0, the head is popped into the output stage: WE←1, A3←head.addr, WD3←head.data. When COUNT==0, WE←0 and A3/WD3 hold their values.
- **COUNT update:** COUNT_next = COUNT + pushes (0–2, counting only non-$0 accepts) − pop (0/1). A simultaneous push and pop at full occupancy is legal only within the ready rules.
- **Forwarding (combinational), per port n:**
  - The lookup searches the valid FIFO entries and the output stage (when WE=1) for addr==An.
  - Priority is youngest first: FIFO tail-1 down to head, then the output stage.
  - An==0 never hits.
  - On a miss, FWDn_DATA=0.
- Pushes accepted in the current cycle are not visible to forwarding until the next cycle.

## Timing

- **Reset (RST low, asynchronous):** WE=0, A3=0, WD3=0, COUNT=0, pointers=0, EMPTY=1. FIFO contents are don't-care. Any in-flight request or queued entry is lost; there is no partial write.
- **Reset release:** LD_READY=ALU_READY=1 in the first cycle after release.
- **Latency:** a request accepted at edge N into an empty queue is on WE/A3/WD3 after edge N+1. The register file commits it at edge N+2.
- **Throughput:** one write per cycle out; up to two accepts per cycle in.
- **Forwarding coverage:** a value remains forwardable from the cycle after acceptance through the cycle it sits on the output stage.
- READY outputs never depend on VALID of the same source; ALU_READY depends on LD_VALID.

## Test plan

- **Reset mid-operation:** RST low with COUNT=3 and WE=1 → immediately WE=0, A3=0, WD3=0, COUNT=0, EMPTY=1; after release, LD_READY=ALU_READY=1.
- **Single write:**
  - Stimulus: ALU_VALID=1, ALU_ADDR=5, ALU_DATA=0x12345678, accepted at edge N.
  - Response: after edge N+1, WE=1, A3=5, WD3=0x12345678; after edge N+2, WE=0, EMPTY=1.
- **Dual accept:**
  - Stimulus: LD (addr 3, 0xAAAA0000) and ALU (addr 4, 0xBBBB0000) in the same cycle on an empty queue.
  - Response: COUNT=2; outputs show addr 3, then addr 4, on consecutive cycles.
- **Full and backpressure:**
  - Stimulus: hold both sources valid with DEPTH=4.
  - Response: ALU_READY drops at COUNT=3 while LD_VALID=1, and LD_READY drops at COUNT=4. No request is lost or duplicated across pointer wrap after 10 mixed writes.
- **$0 discard:** ALU_ADDR=0 accepted → COUNT unchanged, WE never asserted for it, FWD hit never raised for A1=0.
- **Forwarding priority:**
  - Stimulus: queue addr 7 with data 0x1, then addr 7 with data 0x2; set A1=7, A2=8.
  - Response: FWD1_HIT=1 with FWD1_DATA=0x2; FWD2_HIT=0 with FWD2_DATA=0. FWD1_DATA becomes 0x2 from the output stage once the older entry has drained.
